// File: rtl/bitwise_logic_unit.sv
// Registered WIDTH-bit bitwise logic unit with an OR-accumulate reduction mode.
// One output register stage, valid/ready on both sides, result flags registered with data.
module bitwise_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic             acc_active
);

  localparam logic [2:0] OP_ACC = 3'd7;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             par_q, par_d;
  logic             act_q, act_d;

  logic [WIDTH-1:0] result;
  logic             accept;
  logic             produce;
  logic             is_acc;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_acc   = (in_op == OP_ACC);
  // Non-final accumulate beats update acc only; everything else loads the output stage.
  assign produce  = accept && (!is_acc || in_last);

  always_comb begin
    result = '0;
    case (in_op)
      3'd0:    result = in_a & in_b;
      3'd1:    result = in_a | in_b;
      3'd2:    result = in_a ^ in_b;
      3'd3:    result = ~(in_a | in_b);
      3'd4:    result = ~(in_a & in_b);
      3'd5:    result = ~(in_a ^ in_b);
      3'd6:    result = ~in_a;
      default: result = acc_q | in_a | in_b;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    par_d   = par_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    act_d   = act_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (produce) begin
      data_d  = result;
      zero_d  = (result == '0);
      ones_d  = &result;
      par_d   = ^result;
      valid_d = 1'b1;
    end

    if (accept && is_acc) begin
      if (in_last) begin
        acc_d = '0;
        act_d = 1'b0;
      end else begin
        acc_d = result;
        act_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      acc_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
      act_q   <= act_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = par_q;
  assign acc_active = act_q;

endmodule
